// File: rtl/ex_stage_alu_pkg.sv
// ----------------------------------------------------------------------------
// ex_stage_alu_pkg
// Shared definitions for the execute stage and the ALU-control decoder that
// feeds it: the 4-bit operation-select codes and a legality helper.
// Optional feature macro used by the consumers: EX_OVERFLOW_TRAP_EN.
// ----------------------------------------------------------------------------
package ex_stage_alu_pkg;

    localparam int unsigned OP_SEL_W = 4;

    localparam logic [OP_SEL_W-1:0] OP_AND = 4'h0;
    localparam logic [OP_SEL_W-1:0] OP_OR  = 4'h1;
    localparam logic [OP_SEL_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_SEL_W-1:0] OP_SUB = 4'h6;
    localparam logic [OP_SEL_W-1:0] OP_SLT = 4'h7;

    // True when the code is one of the five supported operations.
    function automatic logic op_is_legal(input logic [OP_SEL_W-1:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage : ex_stage_alu_pkg

// File: rtl/ex_stage_alu_alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU for the execute stage.
// Ports:
//   op_sel_i     operation select (AND/OR/ADD/SUB/SLT)
//   a_i, b_i     operands
//   result_o     ALU result (0 for an unknown op)
//   illegal_o    op_sel_i is not a supported code
//   overflow_o   signed overflow on ADD/SUB; tied to 0 unless the
//                EX_OVERFLOW_TRAP_EN macro is defined
// ----------------------------------------------------------------------------
module alu_core
    import ex_stage_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [OP_SEL_W-1:0] op_sel_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [DATA_W-1:0]   result_o,
    output logic                illegal_o,
    output logic                overflow_o
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_sel_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_ADD:  result_o = sum;
            OP_SUB:  result_o = diff;
            // Signed compare rather than the sign of diff, which is wrong
            // whenever the subtraction overflows.
            OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: illegal_o = 1'b1;
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic add_ovf;
    logic sub_ovf;

    // ADD: same-signed operands producing a result of the other sign.
    assign add_ovf = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
    // SUB: opposite-signed operands where the result sign departs from a.
    assign sub_ovf = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);

    always_comb begin
        overflow_o = 1'b0;
        if (op_sel_i == OP_ADD) begin
            overflow_o = add_ovf;
        end else if (op_sel_i == OP_SUB) begin
            overflow_o = sub_ovf;
        end
    end
`else
    assign overflow_o = 1'b0;
`endif

endmodule : alu_core

// File: rtl/ex_stage_alu.sv
// ----------------------------------------------------------------------------
// ex_stage_alu
// Execute stage: computes the ALU result/zero flag from the ID/EX operands and
// captures result plus carried control bits into a one-entry EX/MEM register
// with a valid/ready handshake, backpressure stall and flush.
// Optional feature macro: EX_OVERFLOW_TRAP_EN (signed-overflow trap on
// ADD/SUB; when undefined ovf_trap is constant 0).
// Ports:
//   clk, reset (sync, active high), flush (kill stored and incoming entry)
//   in_valid / in_ready            upstream handshake (in_ready combinational)
//   op_sel, src_a, src_b           ALU operation and operands
//   store_data_in, rd_in           carried data / destination
//   reg_write_in, mem_read_in, mem_write_in, branch_in  carried control
//   out_valid / out_ready          downstream handshake
//   alu_result, zero, store_data_out, rd_out, *_out control,
//   illegal_op, ovf_trap           registered EX/MEM entry
// ----------------------------------------------------------------------------
module ex_stage_alu
    import ex_stage_alu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op_sel,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  branch_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     alu_result,
    output logic                  zero,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  branch_out,
    output logic                  illegal_op,
    output logic                  ovf_trap
);

    logic [DATA_W-1:0] alu_res;
    logic              alu_illegal;
    logic              alu_ovf;
    logic              accept;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .op_sel_i   (op_sel),
        .a_i        (src_a),
        .b_i        (src_b),
        .result_o   (alu_res),
        .illegal_o  (alu_illegal),
        .overflow_o (alu_ovf)
    );

    logic                  valid_q,     valid_d;
    logic [DATA_W-1:0]     result_q,    result_d;
    logic                  zero_q,      zero_d;
    logic [DATA_W-1:0]     store_q,     store_d;
    logic [REG_ADDR_W-1:0] rd_q,        rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  branch_q,    branch_d;
    logic                  illegal_q,   illegal_d;
    logic                  ovf_q,       ovf_d;

    // A full register that is draining this cycle can be refilled at once.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d     = valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        store_d     = store_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        branch_d    = branch_q;
        illegal_d   = illegal_q;
        ovf_d       = ovf_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            store_d     = store_data_in;
            rd_d        = rd_in;
            // Illegal ops and overflow traps must not commit any side effect;
            // branch still flows so the branch unit sees the slot.
            reg_write_d = reg_write_in && !alu_illegal && !alu_ovf;
            mem_read_d  = mem_read_in  && !alu_illegal;
            mem_write_d = mem_write_in && !alu_illegal && !alu_ovf;
            branch_d    = branch_in;
            illegal_d   = alu_illegal;
            ovf_d       = alu_ovf;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            store_q     <= store_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            illegal_q   <= illegal_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid      = valid_q;
    assign alu_result     = result_q;
    assign zero           = zero_q;
    assign store_data_out = store_q;
    assign rd_out         = rd_q;
    assign reg_write_out  = reg_write_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign branch_out     = branch_q;
    assign illegal_op     = illegal_q;
    assign ovf_trap       = ovf_q;

endmodule : ex_stage_alu

// File: tb/tb_ex_stage_alu.sv
// ----------------------------------------------------------------------------
// tb_ex_stage_alu
// Self-checking bench for ex_stage_alu: directed cases followed by random
// traffic, all compared against a behavioural model of the EX/MEM entry.
// ----------------------------------------------------------------------------
module tb_ex_stage_alu;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op_sel;
    logic [31:0] src_a, src_b, store_data_in, alu_result, store_data_out;
    logic [4:0]  rd_in, rd_out;
    logic        reg_write_in, mem_read_in, mem_write_in, branch_in;
    logic        zero, reg_write_out, mem_read_out, mem_write_out, branch_out;
    logic        illegal_op, ovf_trap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_stage_alu #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op_sel         (op_sel),
        .src_a          (src_a),
        .src_b          (src_b),
        .store_data_in  (store_data_in),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .branch_in      (branch_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_result     (alu_result),
        .zero           (zero),
        .store_data_out (store_data_out),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .branch_out     (branch_out),
        .illegal_op     (illegal_op),
        .ovf_trap       (ovf_trap)
    );

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        z;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, ill, ovf;
    } ent_t;

    ent_t m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference entry built from the current inputs using plain integer math.
    function automatic ent_t model_entry();
        ent_t   e;
        longint sa, sb, full;
        logic   ovf;
        sa  = longint'($signed(src_a));
        sb  = longint'($signed(src_b));
        ovf = 1'b0;
        e.ill = 1'b0;
        e.res = 32'h0;
        case (op_sel)
            4'h0: e.res = src_a & src_b;
            4'h1: e.res = src_a | src_b;
            4'h2: begin
                full  = sa + sb;
                e.res = full[31:0];
                ovf   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'h6: begin
                full  = sa - sb;
                e.res = full[31:0];
                ovf   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'h7: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
`ifndef EX_OVERFLOW_TRAP_EN
        ovf = 1'b0;
`endif
        e.v   = 1'b1;
        e.z   = (e.res == 32'h0);
        e.sd  = store_data_in;
        e.rd  = rd_in;
        e.ovf = ovf;
        e.rw  = reg_write_in && !e.ill && !ovf;
        e.mr  = mem_read_in && !e.ill;
        e.mw  = mem_write_in && !e.ill && !ovf;
        e.br  = branch_in;
        return e;
    endfunction

    function automatic ent_t zero_entry();
        ent_t e;
        e.v = 0; e.res = 0; e.z = 0; e.sd = 0; e.rd = 0;
        e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 0; e.ovf = 0;
        return e;
    endfunction

    task automatic check_outputs();
        check("out_valid", {63'b0, out_valid}, {63'b0, m.v});
        if (m.v || reset) begin
            check("alu_result",     {32'b0, alu_result},     {32'b0, m.res});
            check("zero",           {63'b0, zero},           {63'b0, m.z});
            check("store_data_out", {32'b0, store_data_out}, {32'b0, m.sd});
            check("rd_out",         {59'b0, rd_out},         {59'b0, m.rd});
            check("reg_write_out",  {63'b0, reg_write_out},  {63'b0, m.rw});
            check("mem_read_out",   {63'b0, mem_read_out},   {63'b0, m.mr});
            check("mem_write_out",  {63'b0, mem_write_out},  {63'b0, m.mw});
            check("branch_out",     {63'b0, branch_out},     {63'b0, m.br});
            check("illegal_op",     {63'b0, illegal_op},     {63'b0, m.ill});
            check("ovf_trap",       {63'b0, ovf_trap},       {63'b0, m.ovf});
        end
    endtask

    // One clock: inputs are already driven (just after a negedge).
    task automatic step();
        logic rdy;
        #1;
        rdy = !m.v || out_ready;
        check("in_ready", {63'b0, in_ready}, {63'b0, rdy});
        @(posedge clk);
        if (reset)                 m = zero_entry();
        else if (flush)            m.v = 1'b0;
        else if (in_valid && rdy)  m = model_entry();
        else if (out_ready)        m.v = 1'b0;
        @(negedge clk);
        check_outputs();
        $display("cyc t=%0t rst=%0b fl=%0b iv=%0b or=%0b op=%0h a=%08h b=%08h -> ov=%0b res=%08h z=%0b ill=%0b ovf=%0b",
                 $time, reset, flush, in_valid, out_ready, op_sel, src_a, src_b,
                 out_valid, alu_result, zero, illegal_op, ovf_trap);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rw, input logic mr, input logic mw, input logic br);
        in_valid      = 1'b1;
        op_sel        = op;
        src_a         = a;
        src_b         = b;
        reg_write_in  = rw;
        mem_read_in   = mr;
        mem_write_in  = mw;
        branch_in     = br;
        rd_in         = 5'($urandom_range(0, 31));
        store_data_in = $urandom;
    endtask

    initial begin
        m = zero_entry();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // ADD overflow corner
        drive(4'h2, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("add_wrap", {32'b0, alu_result}, 64'h8000_0000);
`ifdef EX_OVERFLOW_TRAP_EN
        check("add_trap", {63'b0, ovf_trap}, 64'h1);
        check("add_rw",   {63'b0, reg_write_out}, 64'h0);
`else
        check("add_trap", {63'b0, ovf_trap}, 64'h0);
        check("add_rw",   {63'b0, reg_write_out}, 64'h1);
`endif
        // beq-style SUB
        drive(4'h6, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("sub_zero", {63'b0, zero}, 64'h1);
        check("sub_br",   {63'b0, branch_out}, 64'h1);
        // SLT signed
        drive(4'h7, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("slt_neg", {32'b0, alu_result}, 64'h1);
        drive(4'h0, 32'hF0F0, 32'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("and", {32'b0, alu_result}, 64'h00F0);
        drive(4'h1, 32'hF0F0, 32'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("or", {32'b0, alu_result}, 64'hFFF0);

        // Stall three cycles, then same-cycle drain/refill
        out_ready = 1'b0;
        drive(4'h2, 32'd10, 32'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check("stall_hold", {32'b0, alu_result}, 64'hFFF0);
        out_ready = 1'b1;
        step();
        check("refill", {32'b0, alu_result}, 64'd30);
        check("refill_v", {63'b0, out_valid}, 64'h1);

        // Flush with full register and incoming entry
        drive(4'h2, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        check("flush_v", {63'b0, out_valid}, 64'h0);
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) step();

        // Reset mid-stall
        drive(4'h1, 32'h1234, 32'h5678, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("rst_res", {32'b0, alu_result}, 64'h0);
        reset = 1'b0; out_ready = 1'b1;

        // Illegal opcode
        drive(4'h3, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("ill_flag", {63'b0, illegal_op}, 64'h1);
        check("ill_mw",   {63'b0, mem_write_out}, 64'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            case ($urandom_range(0, 6))
                0: op = 4'h0; 1: op = 4'h1; 2: op = 4'h2; 3: op = 4'h6;
                4: op = 4'h7; default: op = 4'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: a = 32'h7FFF_FFFF;
                1: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ex_stage_alu

// File: doc/ex_stage_alu.md
Name: ex_stage_alu

Overview:
- Execute stage directly downstream of the ALU-control decoder.
- Consumes the 4-bit operation select plus the ID/EX operands and control bits, then computes the ALU result and zero flag.
- Captures everything into a one-entry EX/MEM output register with a valid/ready handshake.
- Supports stall via downstream backpressure and flush via a pipeline-kill input.

Parameters:
- DATA_W, 32, operand/result width.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill: discard the stored entry and any entry accepted this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- op_sel  in  4  0x0 AND, 0x1 OR, 0x2 ADD, 0x6 SUB, 0x7 SLT.
- src_a  in  DATA_W  operand A (rs).
- src_b  in  DATA_W  operand B (rt or sign-extended immediate).
- store_data_in  in  DATA_W  rt value for sw.
- rd_in  in  REG_ADDR_W  destination register.
- reg_write_in, mem_read_in, mem_write_in, branch_in  in  1 each  control bits carried through.
- out_valid  out  1  EX/MEM entry valid.
- out_ready  in  1  downstream accepts this cycle.
- alu_result  out  DATA_W  registered result.
- zero  out  1  registered (result == 0).
- store_data_out  out  DATA_W  registered store data.
- rd_out  out  REG_ADDR_W  registered destination.
- reg_write_out, mem_read_out, mem_write_out, branch_out  out  1 each  registered control bits.
- illegal_op  out  1  registered: op_sel was not one of the five codes.
- ovf_trap  out  1  registered overflow trap (see Optional Feature).

Behaviour:
- Reset: out_valid=0; alu_result=0; zero=0; store_data_out=0; rd_out=0; all control outputs=0; illegal_op=0; ovf_trap=0. Reset overrides flush and the handshake.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational, so a full register drains and refills in the same cycle.
  - Accept = in_valid && in_ready.
  - Latency is 1 cycle from accept to out_valid.
- Register update each cycle, in priority order:
  - reset;
  - else flush: out_valid<=0 and a concurrent accept is dropped;
  - else accept: load all fields and set out_valid<=1;
  - else if out_ready: out_valid<=0;
  - else hold all fields (stall).
- Data fields may update without accept only if out_valid stays 0. Verify fields only while out_valid=1.
- Arithmetic:
  - ADD/SUB use modulo 2^DATA_W wrap.
  - SLT: result = {DATA_W-1 zeros, signed(src_a) < signed(src_b)}. Compute it with a signed compare, not the sign of the subtraction.
  - zero = (result == 0) for every op; the beq path uses SUB.
- Unknown op_sel: result=0, zero=1, illegal_op=1, reg_write_out=0, mem_write_out=0, mem_read_out=0. branch_out passes through.
- No combinational path from op_sel/src_* to outputs; all outputs come from the register, except in_ready.

Optional Feature:
- Macro: EX_OVERFLOW_TRAP_EN.
- Enabled:
  - For ADD/SUB, signed overflow is detected: ADD overflows when the operand signs are equal and the result sign differs; SUB overflows when the operand signs differ and the result sign differs from src_a.
  - On overflow: ovf_trap=1, reg_write_out=0 and mem_write_out=0. alu_result still holds the wrapped value.
- Disabled: ovf_trap is constant 0 and no overflow logic is generated.

Decomposition:
- Shared package holds the localparams for the op_sel codes (AND/OR/ADD/SUB/SLT). The ALU-control decoder uses the same package.
- One natural sub-module: alu_core. It is purely combinational: op_sel, a, b -> result, illegal, overflow.
- ex_stage_alu holds the handshake and the output register.

Test Plan:
- ADD 0x7FFFFFFF+1, reg_write_in=1:
  - macro off -> next cycle out_valid=1, alu_result=0x80000000, zero=0, reg_write_out=1, ovf_trap=0.
  - macro on -> same alu_result, ovf_trap=1, reg_write_out=0.
- SUB 5-5 with branch_in=1 -> alu_result=0, zero=1, branch_out=1.
- SLT with src_a=0xFFFFFFFF, src_b=1 -> alu_result=1.
  - Also check AND 0xF0F0 & 0x0FF0 = 0x00F0 and OR = 0xFFF0.
- Stall: fill the register, then hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged.
  - Then raise out_ready -> same-cycle accept; the new entry appears the next cycle with no bubble.
- Flush while the register is full and in_valid=1 -> next cycle out_valid=0, the entry is dropped, and no stale entry appears later.
  - Reset asserted mid-stall -> all outputs zero on the next edge.
- op_sel=0x3 with reg_write_in=1, mem_write_in=1 -> illegal_op=1, alu_result=0, zero=1, reg_write_out=0, mem_write_out=0.
